// File: rtl/lift_motion_ctrl.sv
// lift_motion_ctrl: accepts a target floor, pulses sus/jos until the counter reaches it, then holds the door.
// Optional `define DOOR_SENSOR_EN adds door_obstacle, which restarts the door hold time while asserted.
module lift_motion_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    input  logic [FLOOR_W-1:0] etaj_curent,
`ifdef DOOR_SENSOR_EN
    input  logic               door_obstacle,
`endif
    output logic               sus,
    output logic               jos,
    output logic               door_open,
    output logic               arrived,
    output logic               busy,
    output logic               fault
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        STEP,
        DOOR_OPEN
    } state_e;

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   target_q, target_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 dir_up_q, dir_up_d;
    logic                 sus_q, sus_d;
    logic                 jos_q, jos_d;
    logic                 door_open_q, door_open_d;
    logic                 arrived_q, arrived_d;
    logic                 fault_q, fault_d;
    logic                 obstacle;

`ifdef DOOR_SENSOR_EN
    assign obstacle = door_obstacle;
`else
    assign obstacle = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        sus_d       = 1'b0;
        jos_d       = 1'b0;
        door_open_d = 1'b0;
        arrived_d   = 1'b0;
        fault_d     = fault_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_floor;
                    if ({1'b0, req_floor} >= FLOOR_LIMIT) begin
                        fault_d = 1'b1;
                    end else if (req_floor == etaj_curent) begin
                        state_d     = DOOR_OPEN;
                        arrived_d   = 1'b1;
                        door_open_d = 1'b1;
                        timer_d     = DOOR_LOAD;
                    end else begin
                        state_d  = MOVE;
                        timer_d  = TRAVEL_LOAD;
                        dir_up_d = (req_floor > etaj_curent);
                    end
                end
            end

            MOVE: begin
                if (timer_q == '0) begin
                    sus_d   = dir_up_q;
                    jos_d   = ~dir_up_q;
                    state_d = STEP;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            STEP: begin
                // The counter has applied the pulse by now; never command a step past either end.
                if (etaj_curent == target_q) begin
                    state_d     = DOOR_OPEN;
                    arrived_d   = 1'b1;
                    door_open_d = 1'b1;
                    timer_d     = DOOR_LOAD;
                end else if ((dir_up_q && etaj_curent == TOP_FLOOR) ||
                             (!dir_up_q && etaj_curent == '0)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = MOVE;
                    timer_d = TRAVEL_LOAD;
                end
            end

            DOOR_OPEN: begin
                door_open_d = 1'b1;
                if (obstacle) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q == '0) begin
                    state_d     = IDLE;
                    door_open_d = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            timer_q     <= '0;
            dir_up_q    <= 1'b0;
            sus_q       <= 1'b0;
            jos_q       <= 1'b0;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            dir_up_q    <= dir_up_d;
            sus_q       <= sus_d;
            jos_q       <= jos_d;
            door_open_q <= door_open_d;
            arrived_q   <= arrived_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sus       = sus_q;
    assign jos       = jos_q;
    assign door_open = door_open_q;
    assign arrived   = arrived_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Self-checking bench for lift_motion_ctrl: timeline model per accepted request plus a floor-counter plant.
module tb_lift_motion_ctrl;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int TC = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic          req_ready;
    logic [FW-1:0] etaj_curent = '0;
    logic          sus, jos, door_open, arrived, busy, fault;
`ifdef DOOR_SENSOR_EN
    logic          door_obstacle = 1'b0;
`endif

    lift_motion_ctrl #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .TRAVEL_CYCLES(TC),
        .DOOR_CYCLES  (DC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .req_ready  (req_ready),
        .etaj_curent(etaj_curent),
`ifdef DOOR_SENSOR_EN
        .door_obstacle(door_obstacle),
`endif
        .sus        (sus),
        .jos        (jos),
        .door_open  (door_open),
        .arrived    (arrived),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model of the current request: a timeline relative to the accept edge.
    bit m_idle = 1'b1, m_active = 1'b0, m_up = 1'b0, m_glitch = 1'b0, m_fault = 1'b0;
    int acc_cyc = 0, npl = 0, door_start = 0, end_rel = 0, glitch_m = 0, force_glitch = 0, pulse_idx = 0;

    // Observed per-request tallies, used for the hand-computed pins.
    int t_acc = 0, t_sus = 0, t_jos = 0, t_door = 0, t_arr = 0;
    int t_arr_rel = -1, t_arr_floor = -1, t_ready_rel = -1;
    int t_pulse_rel[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int r, start, tgt, n, boundary, last;
        bit e_pulse, e_door, e_arr;
        @(negedge clk);
        cyc++;
        if (reset_n && req_valid && m_idle) begin
            t_acc = cyc; t_sus = 0; t_jos = 0; t_door = 0; t_arr = 0;
            t_arr_rel = -1; t_arr_floor = -1; t_ready_rel = -1;
            for (int i = 0; i < 4; i++) t_pulse_rel[i] = -1;
            start = int'(etaj_curent);
            tgt   = int'(req_floor);
            if (tgt >= NF) begin
                m_fault = 1'b1;
            end else begin
                m_active  = 1'b1;
                acc_cyc   = cyc;
                m_up      = (tgt > start);
                n         = m_up ? tgt - start : start - tgt;
                pulse_idx = 0;
                m_glitch  = 1'b0;
                boundary  = m_up ? NF - 1 : 0;
                if (n > 0 && tgt != boundary && (force_glitch != 0 || $urandom_range(0, 5) == 0)) begin
                    m_glitch = 1'b1;
                    glitch_m = (force_glitch != 0) ? force_glitch : int'($urandom_range(1, n));
                end
                force_glitch = 0;
                npl = m_glitch ? glitch_m : n;
                if (n == 0) begin
                    door_start = 0;
                    end_rel    = DC;
                end else begin
                    last = TC + (npl - 1) * (TC + 1);
                    if (m_glitch) begin
                        door_start = -1000;
                        end_rel    = last + 1;
                    end else begin
                        door_start = last + 1;
                        end_rel    = door_start + DC;
                    end
                end
            end
        end else if (m_active && (cyc - acc_cyc) >= end_rel) begin
            m_active = 1'b0;
            if (m_glitch) m_fault = 1'b1;
        end

        r       = cyc - acc_cyc;
        e_pulse = m_active && r >= TC && ((r - TC) % (TC + 1)) == 0 && ((r - TC) / (TC + 1)) < npl;
        e_door  = m_active && r >= door_start && r < door_start + DC;
        e_arr   = m_active && r == door_start;
        check("sus",       int'(sus),       int'(e_pulse && m_up));
        check("jos",       int'(jos),       int'(e_pulse && !m_up));
        check("door_open", int'(door_open), int'(e_door));
        check("arrived",   int'(arrived),   int'(e_arr));
        check("busy",      int'(busy),      int'(m_active));
        check("req_ready", int'(req_ready), int'(!m_active));
        check("fault",     int'(fault),     int'(m_fault));

        r = cyc - t_acc;
        if (sus || jos) begin
            if (t_sus + t_jos < 4) t_pulse_rel[t_sus + t_jos] = r;
            if (sus) t_sus++;
            if (jos) t_jos++;
        end
        if (door_open) t_door++;
        if (arrived) begin
            t_arr++;
            t_arr_rel   = r;
            t_arr_floor = int'(etaj_curent);
        end
        if (t_ready_rel < 0 && req_ready) t_ready_rel = r;

        // Floor counter plant: applies each pulse within the pulse cycle; optional glitch jumps to an end floor.
        if (sus || jos) begin
            pulse_idx++;
            if (m_glitch && pulse_idx == glitch_m) etaj_curent = m_up ? FW'(NF - 1) : '0;
            else if (sus) etaj_curent = etaj_curent + FW'(1);
            else etaj_curent = etaj_curent - FW'(1);
        end
        m_idle = !m_active;
    endtask

    task automatic run_idle(input int limit);
        int k = 0;
        while (!m_idle && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (!m_idle) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    task automatic request(input int f);
        req_valid = 1'b1;
        req_floor = FW'(f);
        tick();
        req_valid = 1'b0;
        run_idle(200);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_sus",       int'(sus),       0);
        check("rst_jos",       int'(jos),       0);
        check("rst_door_open", int'(door_open), 0);
        check("rst_arrived",   int'(arrived),   0);
        check("rst_fault",     int'(fault),     0);
        check("rst_busy",      int'(busy),      0);
        check("rst_req_ready", int'(req_ready), 1);
        m_active = 1'b0;
        m_fault  = 1'b0;
        m_idle   = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("reset_ready", int'(req_ready), 1);
        check("reset_busy",  int'(busy),      0);
        check("reset_fault", int'(fault),     0);
        reset_n = 1'b1;
        tick();

        // 0 -> 3: three up pulses 5 cycles apart, arrival at rel 15, door for 8, ready at 23.
        etaj_curent = FW'(0);
        request(3);
        check("t1_sus_cnt",  t_sus, 3);
        check("t1_jos_cnt",  t_jos, 0);
        check("t1_pulse0",   t_pulse_rel[0], 4);
        check("t1_pulse1",   t_pulse_rel[1], 9);
        check("t1_pulse2",   t_pulse_rel[2], 14);
        check("t1_arr_cnt",  t_arr, 1);
        check("t1_arr_rel",  t_arr_rel, 15);
        check("t1_arr_fl",   t_arr_floor, 3);
        check("t1_door_cnt", t_door, 8);
        check("t1_ready",    t_ready_rel, 23);

        // 5 -> 2: three down pulses.
        etaj_curent = FW'(5);
        tick();
        request(2);
        check("t2_jos_cnt", t_jos, 3);
        check("t2_sus_cnt", t_sus, 0);
        check("t2_arr_fl",  t_arr_floor, 2);

        // Same floor: no pulses, immediate arrival.
        etaj_curent = FW'(4);
        tick();
        request(4);
        check("t3_pulses",   t_sus + t_jos, 0);
        check("t3_arr_rel",  t_arr_rel, 0);
        check("t3_door_cnt", t_door, 8);
        check("t3_ready",    t_ready_rel, 8);

        // 6 -> 7: reaches the top floor normally.
        etaj_curent = FW'(6);
        tick();
        request(7);
        check("t4_sus_cnt", t_sus, 1);
        check("t4_arr_fl",  t_arr_floor, 7);
        check("t4_fault",   int'(fault), 0);

        // 3 -> 5 with the counter jumping to the top after the first pulse: fault, no further pulse.
        etaj_curent = FW'(3);
        force_glitch = 1;
        tick();
        request(5);
        check("t5_sus_cnt", t_sus, 1);
        check("t5_fault",   int'(fault), 1);
        check("t5_ready",   t_ready_rel, 5);
        check("t5_door",    t_door, 0);

        // Reset mid-move with the timer at 2; also clears the sticky fault.
        etaj_curent = FW'(0);
        tick();
        req_valid = 1'b1;
        req_floor = FW'(3);
        tick();
        req_valid = 1'b0;
        tick();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        check("t6_sus_cnt", t_sus, 0);
        check("t6_floor",   int'(etaj_curent), 0);
        check("t6_ready",   int'(req_ready), 1);

        // Out-of-range request: fault, stays idle.
        request(8);
        check("t7_fault", int'(fault), 1);
        check("t7_busy",  int'(busy), 0);
        check("t7_ready", t_ready_rel, 0);
        do_reset();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) req_valid = ~req_valid;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 29) == 0) req_floor = FW'($urandom_range(NF, (1 << FW) - 1));
                else req_floor = FW'($urandom_range(0, NF - 1));
            end
            if (m_idle && $urandom_range(0, 7) == 0) etaj_curent = FW'($urandom_range(0, NF - 1));
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end
        req_valid = 1'b0;
        run_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
